ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001: Parameter CLK_FREQ_HZ, default 50000000, system clock frequency in Hz.
REQ-002: Parameter INHIBIT_US, default 100, time in microseconds that the host holds PS/2 clock low before request-to-send.
REQ-003: Parameter TIMEOUT_US, default 2000, maximum time in microseconds allowed between successive device clock falling edges, and before the first one.
REQ-004: Parameter SYNC_STAGES, default 2, number of synchroniser flops on each sampled PS/2 line (minimum 2).
REQ-005: clk  input  1  system clock; all logic is on the rising edge.
REQ-006: reset  input  1  asynchronous, active-high reset.
REQ-007: ps2_clock  inout  1  PS/2 clock line; open-drain, driven 0 or high-Z only.
REQ-008: ps2_data  inout  1  PS/2 data line; open-drain, driven 0 or high-Z only.
REQ-009: command_send  input  1  single-cycle request to transmit `command`.
REQ-010: command  input  8  byte to send; sampled only in the cycle command_send is accepted.
REQ-011: busy  output  1  high from acceptance until the DONE or ERROR pulse.
REQ-012: rx_inhibit  output  1  high while busy; the receiver must ignore line activity while it is high.
REQ-013: done  output  1  one-cycle pulse when the device acknowledges.
REQ-014: error  output  1  one-cycle pulse when a transfer is aborted.
REQ-015: error_code  output  2  cause, valid with error: 01 timeout, 10 no ACK; otherwise 00.

Function
REQ-016: INHIBIT_CYC = CLK_FREQ_HZ/1000000*INHIBIT_US and TIMEOUT_CYC = CLK_FREQ_HZ/1000000*TIMEOUT_US; counter width is $clog2 of the larger value plus 1.
REQ-017: ps2_clock and ps2_data are sampled through SYNC_STAGES flops; a device falling edge is synchronised previous=1 and current=0.
REQ-018: States are IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE, ERROR.
REQ-019: IDLE: both lines high-Z; command_send=1 latches command, computes odd parity (parity bit = ~^command), clears the counter and moves to INHIBIT.
REQ-020: command_send is ignored while busy=1; no queueing.
REQ-021: INHIBIT: drive ps2_clock=0 and ps2_data=Z for INHIBIT_CYC cycles, then go to RTS.
REQ-022: RTS: drive ps2_data=0 (start bit), keep ps2_clock=0 for exactly 1 cycle, then release ps2_clock and go to SHIFT with bit index 0 and the timeout counter cleared.
REQ-023: SHIFT: on each device falling edge, present frame bit[index] on ps2_data and increment the index.
REQ-024: Frame order: d0..d7, parity, stop; the stop bit releases ps2_data (Z).
REQ-025: Presenting a 1 on ps2_data means high-Z; presenting a 0 means driving low.
REQ-026: After the stop bit has been presented (10 edges), go to ACK.
REQ-027: ACK: on the next falling edge, sample synchronised ps2_data; 0 goes to WAIT_IDLE, 1 goes to ERROR with code 10.
REQ-028: WAIT_IDLE: once synchronised clock and data are both 1, go to DONE.
REQ-029: DONE: pulse done for 1 cycle, then return to IDLE.
REQ-030: ERROR: pulse error with error_code for 1 cycle, release both lines, then return to IDLE.
REQ-031: In SHIFT, ACK and WAIT_IDLE the timeout counter is cleared on every falling edge; reaching TIMEOUT_CYC goes to ERROR with code 01.
REQ-032: A falling edge arriving in the same cycle the timeout is reached is treated as the timeout.
REQ-033: done and error are never high together; error_code is 00 whenever error=0.

Reset
REQ-034: reset=1, including mid-transfer, immediately releases both lines (Z), forces state IDLE, and clears busy, rx_inhibit, done, error, error_code, the counters, the index and the shift register.
REQ-035: The synchroniser flops reset to 1.
REQ-036: The first command is accepted in the first cycle after reset deasserts.

Verification (CLK_FREQ_HZ=50000000, INHIBIT_US=100, TIMEOUT_US=2000)
REQ-037: Send 0xF4 to a device model that ACKs -> clock held low for 5000 cycles; data bits sampled on rising edges are 0,0,1,0,1,1,1,1, then parity 0 and stop 1; done pulses once; error never asserts.
REQ-038: Send 0xED -> parity bit 1; send 0xFF -> parity bit 1; send 0x00 -> parity bit 1.
REQ-039: Device model never clocks after RTS -> error pulses with code 01 exactly 100000 cycles after clock release; both lines then read high.
REQ-040: Device model leaves data high on the 11th clock -> error pulses with code 10; done never asserts.
REQ-041: Assert command_send again while busy with a different byte -> the frame still carries the first byte; only one done pulse.
REQ-042: Assert reset during SHIFT after 4 bits -> both lines are Z in the same cycle and busy=0; a following send of 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Command/status bundle between a PS/2 host transmitter and its client.
// The client (master) issues byte commands and observes the transfer outcome.
interface ps2_host_tx_if;
  logic       command_send;
  logic [7:0] command;
  logic       busy;
  logic       rx_inhibit;
  logic       done;
  logic       error;
  logic [1:0] error_code;

  modport master (
    output command_send, command,
    input  busy, rx_inhibit, done, error, error_code
  );

  modport slave (
    input  command_send, command,
    output busy, rx_inhibit, done, error, error_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift the frame on
// device clock falls, check the device ACK, then report done or error.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 2000,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  inout  wire          ps2_clock,
  inout  wire          ps2_data,
  ps2_host_tx_if.slave host
);

  localparam int SS          = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int INHIBIT_CYC = CLK_FREQ_HZ / 1000000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int MAX_CYC     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW          = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] CNT_ZERO     = CW'(0);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
  // One less than the limit so the error pulse lands exactly TIMEOUT_CYC cycles in.
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  state_t          state_r, state_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic [3:0]      idx_r, idx_n;
  logic [9:0]      frame_r, frame_n;
  logic            data_oe_r, data_oe_n;
  logic [1:0]      code_n;
  logic            clk_oe_r;
  logic            busy_r, done_r, error_r;
  logic [1:0]      error_code_r;
  logic [SS-1:0]   clk_sync_r, data_sync_r;
  logic            clk_prev_r;
  logic            clk_cur_s, data_cur_s, fall_s;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  assign ps2_clock = clk_oe_r  ? 1'b0 : 1'bz;
  assign ps2_data  = data_oe_r ? 1'b0 : 1'bz;

  assign clk_cur_s  = clk_sync_r[SS-1];
  assign data_cur_s = data_sync_r[SS-1];
  assign fall_s     = clk_prev_r & ~clk_cur_s;

  assign host.busy       = busy_r;
  assign host.rx_inhibit = busy_r;
  assign host.done       = done_r;
  assign host.error      = error_r;
  assign host.error_code = error_code_r;

  // Line synchronisers; idle lines are high, so the flops reset to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_r  <= {SS{1'b1}};
      data_sync_r <= {SS{1'b1}};
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SS-2:0], ps2_clock};
      data_sync_r <= {data_sync_r[SS-2:0], ps2_data};
      clk_prev_r  <= clk_sync_r[SS-1];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state, counter, index and frame logic.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    idx_n     = idx_r;
    frame_n   = frame_r;
    data_oe_n = data_oe_r;
    code_n    = 2'b00;
    case (state_r)
      IDLE: begin
        data_oe_n = 1'b0;
        if (host.command_send) begin
          frame_n = {1'b1, odd_parity(host.command), host.command};
          cnt_n   = CNT_ZERO;
          idx_n   = 4'd0;
          state_n = INHIBIT;
        end else begin
          cnt_n = CNT_ZERO;
        end
      end
      INHIBIT: begin
        if (cnt_r == INHIBIT_LAST) begin
          cnt_n     = CNT_ZERO;
          data_oe_n = 1'b1;
          state_n   = RTS;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      RTS: begin
        data_oe_n = 1'b1;
        cnt_n     = CNT_ZERO;
        idx_n     = 4'd0;
        state_n   = SHIFT;
      end
      SHIFT: begin
        if (cnt_r == TIMEOUT_LAST) begin
          code_n  = 2'b01;
          state_n = ERROR;
        end else if (fall_s) begin
          data_oe_n = ~frame_r[idx_r];
          idx_n     = idx_r + 4'd1;
          cnt_n     = CNT_ZERO;
          if (idx_r == 4'd9) begin
            state_n = ACK;
          end else begin
            state_n = SHIFT;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      ACK: begin
        data_oe_n = 1'b0;
        if (cnt_r == TIMEOUT_LAST) begin
          code_n  = 2'b01;
          state_n = ERROR;
        end else if (fall_s) begin
          cnt_n = CNT_ZERO;
          if (data_cur_s) begin
            code_n  = 2'b10;
            state_n = ERROR;
          end else begin
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        data_oe_n = 1'b0;
        if (cnt_r == TIMEOUT_LAST) begin
          code_n  = 2'b01;
          state_n = ERROR;
        end else if (clk_cur_s && data_cur_s) begin
          state_n = DONE;
        end else if (fall_s) begin
          cnt_n = CNT_ZERO;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
      ERROR: begin
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
      default: begin
        data_oe_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

  // Datapath and outputs, registered from the next state so they align with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r        <= CNT_ZERO;
      idx_r        <= 4'd0;
      frame_r      <= 10'd0;
      clk_oe_r     <= 1'b0;
      data_oe_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      error_code_r <= 2'b00;
    end else begin
      cnt_r        <= cnt_n;
      idx_r        <= idx_n;
      frame_r      <= frame_n;
      clk_oe_r     <= (state_n == INHIBIT) || (state_n == RTS);
      data_oe_r    <= data_oe_n && ((state_n == RTS) || (state_n == SHIFT));
      busy_r       <= state_n inside {INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE};
      done_r       <= (state_n == DONE);
      error_r      <= (state_n == ERROR);
      error_code_r <= (state_n == ERROR) ? code_n : 2'b00;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and
// each frame is compared with one built from the byte by the framing rules.
module tb_ps2_host_tx;

  // Shortened timings keep the run short; expectations derive from these values.
  localparam int CLK_HZ  = 50000000;
  localparam int INH_US  = 20;
  localparam int TO_US   = 200;
  localparam int INH_CYC = CLK_HZ / 1000000 * INH_US;
  localparam int TO_CYC  = CLK_HZ / 1000000 * TO_US;
  localparam int HALF    = 25;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  wire  ps2_clock;
  wire  ps2_data;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int bad_cnt  = 0;
  logic [1:0] last_code = 2'b00;

  ps2_host_tx_if bus ();

  pullup (ps2_clock);
  pullup (ps2_data);
  assign ps2_clock = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data  = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .INHIBIT_US  (INH_US),
    .TIMEOUT_US  (TO_US),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .host      (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.error) begin
      err_cnt   <= err_cnt + 1;
      last_code <= bus.error_code;
    end
    if ((bus.done && bus.error) || (!bus.error && bus.error_code != 2'b00)) bad_cnt <= bad_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode: 0 ACK, 1 no ACK, 2 device silent, 3 second command while busy, 4 reset after 4 bits
  task automatic transfer(input logic [7:0] b, input int mode);
    int n;
    int d0;
    int e0;
    int ones;
    logic [9:0] got;
    logic [9:0] want;
    d0   = done_cnt;
    e0   = err_cnt;
    got  = 10'd0;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    want = {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};

    bus.command      = b;
    bus.command_send = 1'b1;
    @(negedge clk);
    bus.command_send = 1'b0;
    check("busy_after_accept", bus.busy, 1);

    n = 0;
    while (ps2_clock === 1'b0 && ps2_data === 1'b1 && n < INH_CYC + 100) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH_CYC);
    n = 0;
    while (ps2_clock === 1'b0 && ps2_data === 1'b0 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("rts_len", n, 1);
    check("start_bit", {ps2_clock, ps2_data}, 2'b10);
    check("rx_inhibit", bus.rx_inhibit, 1);

    if (mode == 2) begin
      n = 0;
      while (!bus.error && n < TO_CYC + 100) begin
        n++;
        @(negedge clk);
      end
      check("timeout_delay", n, TO_CYC);
      check("timeout_code", bus.error_code, 2'b01);
      @(negedge clk);
      check("lines_after_timeout", {ps2_clock, ps2_data}, 2'b11);
      check("timeout_no_done", done_cnt - d0, 0);
      return;
    end

    repeat (5) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i <= 10) got[i-1] = ps2_data;
      dev_clk_low = 1'b0;
      if (i == 11) dev_data_low = 1'b0;
      if (mode == 4 && i == 4) begin
        reset = 1'b1;
        #1;
        check("reset_lines", {ps2_clock, ps2_data}, 2'b11);
        check("reset_busy", bus.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (i == 10 && mode != 1) dev_data_low = 1'b1;
      if (mode == 3 && i == 3) begin
        bus.command      = ~b;
        bus.command_send = 1'b1;
        @(negedge clk);
        bus.command_send = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end

    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("frame", got, want);
    check("parity", got[8], want[8]);
    if (mode == 1) begin
      check("nack_error", err_cnt - e0, 1);
      check("nack_code", last_code, 2'b10);
      check("nack_no_done", done_cnt - d0, 0);
    end else begin
      check("done_once", done_cnt - d0, 1);
      check("no_error", err_cnt - e0, 0);
      check("idle_busy", bus.busy, 0);
    end
  endtask

  initial begin
    bus.command_send = 1'b0;
    bus.command      = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_status", {bus.busy, bus.rx_inhibit, bus.done, bus.error, bus.error_code}, 6'b000000);
    check("reset_idle_lines", {ps2_clock, ps2_data}, 2'b11);
    reset = 1'b0;
    transfer(8'hF4, 0);
    transfer(8'hED, 0);
    transfer(8'hFF, 0);
    transfer(8'h00, 0);
    for (int k = 0; k < 6; k++) transfer(8'($urandom_range(0, 255)), 0);
    transfer(8'($urandom_range(0, 255)), 3);
    transfer(8'($urandom_range(0, 255)), 1);
    transfer(8'hF4, 4);
    transfer(8'hF4, 0);
    transfer(8'($urandom_range(0, 255)), 2);
    repeat (10) @(negedge clk);
    check("done_error_exclusive", bad_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
